data_sync_mc: RTL
=================

Name: data_sync_mc

Overview:
- Multi-channel, parametrised successor to the single-bus enable-qualified data synchroniser.
- Each channel takes an unsynchronised data bus plus an enable from a foreign clock domain and passes the enable through an NUM_STAGES flop chain.
- An enable event (rising edge, or any edge in toggle mode) captures the bus into a holding register.
- Each channel presents its captured word through a valid/ready handshake with sticky overrun detection. Sits at the CDC boundary in front of RX/register-file consumers.

Parameters:
- NUM_STAGES, 2, synchroniser depth on each enable; legal values >= 2.
- BUS_WIDTH, 8, data width per channel.
- NUM_CH, 2, number of independent channels; legal values >= 1.
- TOGGLE_MODE, 0, 0 = level enable (event on rising edge), 1 = toggle enable (event on any edge).

Ports:
- CLK  input  1  destination-domain clock.
- RST  input  1  asynchronous reset, active-high.
- UNSYNC_BUS  input  NUM_CH*BUS_WIDTH  channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH].
- BUS_ENABLE  input  NUM_CH  unsynchronised per-channel enable/toggle.
- SYNC_READY  input  NUM_CH  downstream accepts the held word.
- OVR_CLR  input  1  clears all OVERRUN and UNSTABLE flags.
- SYNC_BUS  output  NUM_CH*BUS_WIDTH  held synchronised words.
- SYNC_VALID  output  NUM_CH  held word valid.
- enable_pulse  output  NUM_CH  one-cycle pulse per detected event.
- OVERRUN  output  NUM_CH  sticky: an event arrived while the word was unconsumed.
- UNSTABLE  output  NUM_CH  sticky data-stability error (optional feature; tied 0 otherwise).

Behaviour:
- Reset: asynchronous, active-high, applied to every flop. While RST = 1, all chain flops, last-flop, SYNC_BUS, SYNC_VALID, enable_pulse, OVERRUN and UNSTABLE are 0. Any pending word is dropped.
- Per channel: chain shifts in BUS_ENABLE[c] each CLK edge. sync = last stage; last = sync delayed by one cycle.
- Event (combinational): TOGGLE_MODE = 0 gives sync & ~last; TOGGLE_MODE = 1 gives sync ^ last.
- Latency: BUS_ENABLE first sampled high at edge 1. The event is true after edge NUM_STAGES. enable_pulse and SYNC_BUS/SYNC_VALID update at edge NUM_STAGES+1.
- enable_pulse asserts for exactly one cycle per event, regardless of handshake state.
- Per-channel FSM, states EMPTY and FULL:
  - EMPTY, event: capture UNSYNC_BUS slice, go to FULL, SYNC_VALID = 1.
  - FULL, SYNC_READY with no event: go to EMPTY, SYNC_VALID = 0. SYNC_BUS retains its value.
  - FULL, SYNC_READY and event in the same cycle: capture the new word, stay FULL. This is not an overrun; it gives back-to-back throughput.
  - FULL, event without SYNC_READY: old word kept (no overwrite), OVERRUN[c] set, stay FULL.
  - EMPTY, SYNC_READY with no event: no effect.
- OVERRUN is sticky until OVR_CLR. If OVR_CLR and a new overrun occur in the same cycle, set wins.
- Channels are fully independent. Simultaneous events on several channels are all captured in the same cycle.
- Reset release with BUS_ENABLE held high: the chain fills from 0, so one event is detected and one capture happens NUM_STAGES+1 edges after release. This holds in both modes.
- Upstream contract: UNSYNC_BUS must be stable from the enable change until NUM_STAGES+2 CLK edges later.

Optional Feature:
- Macro DATA_SYNC_STABLE_CHK_EN.
- Defined: each channel registers UNSYNC_BUS one extra cycle. On an event cycle, if the registered copy differs from the current UNSYNC_BUS, UNSTABLE[c] is set. It is sticky, cleared by OVR_CLR, and set wins over clear. Capture still takes the current value.
- Undefined: no extra registers; UNSTABLE is constant 0.

Decomposition:
- Package data_sync_pkg holds:
  - state enum ds_state_e {DS_EMPTY, DS_FULL};
  - mode constants DS_MODE_LEVEL = 0 and DS_MODE_TOGGLE = 1;
  - a function computing the slice offset c*BUS_WIDTH.
- Sub-module data_sync_ch implements one channel: chain, edge detect, FSM, flags, optional check. The top instantiates it NUM_CH times in a generate loop and slices the buses.

Test Plan:
- Reset/latency: NUM_STAGES = 2, RST pulse, BUS_ENABLE[0] 0→1 with UNSYNC_BUS slice = 0xA5 → at edge 3 SYNC_BUS[7:0] = 0xA5, SYNC_VALID[0] = 1, enable_pulse[0] high for exactly one cycle; all outputs 0 during reset.
- Handshake: with word held, SYNC_READY[0] = 1 for one cycle → SYNC_VALID[0] = 0 next cycle, SYNC_BUS unchanged at 0xA5.
- Overrun: word 0x11 held, READY low, new event with 0x22 → SYNC_BUS stays 0x11, OVERRUN[0] = 1; OVR_CLR → 0; OVR_CLR coincident with a new overrun → stays 1.
- Same-cycle accept + event: READY = 1 coincident with event carrying 0x33 → SYNC_BUS = 0x33, SYNC_VALID stays 1, OVERRUN stays 0.
- Toggle mode: TOGGLE_MODE = 1, BUS_ENABLE[1] toggles 0→1→0 with data 0x44 then 0x55, READY held 1 → two enable_pulses, captures 0x44 then 0x55; channel 0 untouched.
- Reset mid-operation and stability: RST asserted while FULL → SYNC_VALID = 0 asynchronously. With DATA_SYNC_STABLE_CHK_EN defined, data changing 0x66→0x67 one cycle before the event → UNSTABLE = 1.

Source files
------------

// File: rtl/data_sync_pkg.sv
// Shared types and helpers for the multi-channel enable-qualified data synchroniser.
// Used by data_sync_ch and data_sync_mc.
package data_sync_pkg;

  typedef enum logic {
    DS_EMPTY = 1'b0,
    DS_FULL  = 1'b1
  } ds_state_e;

  localparam int DS_MODE_LEVEL  = 0;
  localparam int DS_MODE_TOGGLE = 1;

  function automatic int unsigned ds_slice_offset(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/data_sync_ch.sv
// One synchroniser channel: enable chain, edge detect, holding register with valid/ready and sticky flags.
// Optional data-stability check enabled by defining DATA_SYNC_STABLE_CHK_EN.
module data_sync_ch
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int TOGGLE_MODE = DS_MODE_LEVEL
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [BUS_WIDTH-1:0] unsync_bus_i,
  input  logic                 enable_i,
  input  logic                 ready_i,
  input  logic                 ovr_clr_i,
  output logic [BUS_WIDTH-1:0] sync_bus_o,
  output logic                 sync_valid_o,
  output logic                 enable_pulse_o,
  output logic                 overrun_o,
  output logic                 unstable_o
);

  logic [NUM_STAGES-1:0] chain_q;
  logic                  last_q;
  logic                  sync_w;
  logic                  evt_w;
  ds_state_e             state_q, state_d;
  logic [BUS_WIDTH-1:0]  bus_q, bus_d;
  logic                  pulse_q;
  logic                  ovr_q, ovr_d;

  assign sync_w = chain_q[NUM_STAGES-1];
  assign evt_w  = (TOGGLE_MODE == DS_MODE_TOGGLE) ? (sync_w ^ last_q) : (sync_w & ~last_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= '0;
      last_q  <= 1'b0;
      state_q <= DS_EMPTY;
      bus_q   <= '0;
      pulse_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      chain_q <= {chain_q[NUM_STAGES-2:0], enable_i};
      last_q  <= sync_w;
      state_q <= state_d;
      bus_q   <= bus_d;
      pulse_q <= evt_w;
      ovr_q   <= ovr_d;
    end
  end

  // An event while full is only an overrun if the held word is not being accepted in the same cycle.
  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    ovr_d   = ovr_q;
    if (ovr_clr_i) ovr_d = 1'b0;
    case (state_q)
      DS_EMPTY: begin
        if (evt_w) begin
          state_d = DS_FULL;
          bus_d   = unsync_bus_i;
        end
      end
      DS_FULL: begin
        if (evt_w && ready_i) begin
          bus_d = unsync_bus_i;
        end else if (evt_w) begin
          ovr_d = 1'b1;
        end else if (ready_i) begin
          state_d = DS_EMPTY;
        end
      end
    endcase
  end

  assign sync_bus_o     = bus_q;
  assign sync_valid_o   = (state_q == DS_FULL);
  assign enable_pulse_o = pulse_q;
  assign overrun_o      = ovr_q;

`ifdef DATA_SYNC_STABLE_CHK_EN
  logic [BUS_WIDTH-1:0] data_q;
  logic                 unstable_q, unstable_d;

  always_comb begin
    unstable_d = unstable_q;
    if (ovr_clr_i) unstable_d = 1'b0;
    if (evt_w && (data_q != unsync_bus_i)) unstable_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q     <= '0;
      unstable_q <= 1'b0;
    end else begin
      data_q     <= unsync_bus_i;
      unstable_q <= unstable_d;
    end
  end

  assign unstable_o = unstable_q;
`else
  assign unstable_o = 1'b0;
`endif

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel enable-qualified data synchroniser: NUM_CH independent data_sync_ch instances.
// Define DATA_SYNC_STABLE_CHK_EN to enable the per-channel UNSTABLE data check.
module data_sync_mc
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_CH      = 2,
  parameter int TOGGLE_MODE = DS_MODE_LEVEL
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] UNSYNC_BUS,
  input  logic [NUM_CH-1:0]           BUS_ENABLE,
  input  logic [NUM_CH-1:0]           SYNC_READY,
  input  logic                        OVR_CLR,
  output logic [NUM_CH*BUS_WIDTH-1:0] SYNC_BUS,
  output logic [NUM_CH-1:0]           SYNC_VALID,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           OVERRUN,
  output logic [NUM_CH-1:0]           UNSTABLE
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int unsigned Off = ds_slice_offset(c, BUS_WIDTH);

    data_sync_ch #(
      .NUM_STAGES (NUM_STAGES),
      .BUS_WIDTH  (BUS_WIDTH),
      .TOGGLE_MODE(TOGGLE_MODE)
    ) u_ch (
      .clk_i         (CLK),
      .rst_i         (RST),
      .unsync_bus_i  (UNSYNC_BUS[Off +: BUS_WIDTH]),
      .enable_i      (BUS_ENABLE[c]),
      .ready_i       (SYNC_READY[c]),
      .ovr_clr_i     (OVR_CLR),
      .sync_bus_o    (SYNC_BUS[Off +: BUS_WIDTH]),
      .sync_valid_o  (SYNC_VALID[c]),
      .enable_pulse_o(enable_pulse[c]),
      .overrun_o     (OVERRUN[c]),
      .unstable_o    (UNSTABLE[c])
    );
  end

endmodule
